// File: rtl/bp_update_queue.sv
// Commit-to-predictor update FIFO: buffers resolved branches and replays them in
// commit order, one per cycle, with branch and mispredict performance counters.
module bp_update_queue #(
    parameter int QUEUE_DEPTH = 4,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 commit_valid,
    input  logic [31:0]          commit_pc,
    input  logic                 commit_taken,
    input  logic                 commit_mispredict,
    output logic                 commit_ready,
    output logic                 bp_update_en,
    output logic [31:0]          bp_pc,
    output logic                 bp_branch_taken,
    output logic [CNT_WIDTH-1:0] branch_count,
    output logic [CNT_WIDTH-1:0] mispredict_count
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = QUEUE_DEPTH[PTR_W:0];

    logic [31:0]    pc_mem    [QUEUE_DEPTH];
    logic           taken_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic             push;
    logic             pop;

    // Ready is based on occupancy only, never on a same-cycle drain.
    assign commit_ready    = (count < DEPTH_C);
    assign push            = commit_valid && commit_ready;
    assign pop             = (count != '0);
    assign bp_update_en    = pop;
    assign bp_pc           = pc_mem[head];
    assign bp_branch_taken = taken_mem[head];

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail]    <= commit_pc;
            taken_mem[tail] <= commit_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (push) begin
                tail         <= tail + 1'b1;
                branch_count <= branch_count + 1'b1;
                if (commit_mispredict)
                    mispredict_count <= mispredict_count + 1'b1;
            end
            if (pop)
                head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_update_queue.sv
// Randomized bench for bp_update_queue against a queue-based reference model.
module tb_bp_update_queue;

    localparam int DEPTH = 4;
    localparam int CW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          commit_valid;
    logic [31:0]   commit_pc;
    logic          commit_taken;
    logic          commit_mispredict;
    logic          commit_ready;
    logic          bp_update_en;
    logic [31:0]   bp_pc;
    logic          bp_branch_taken;
    logic [CW-1:0] branch_count;
    logic [CW-1:0] mispredict_count;

    bp_update_queue #(.QUEUE_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .commit_valid(commit_valid), .commit_pc(commit_pc),
        .commit_taken(commit_taken), .commit_mispredict(commit_mispredict),
        .commit_ready(commit_ready), .bp_update_en(bp_update_en),
        .bp_pc(bp_pc), .bp_branch_taken(bp_branch_taken),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: pending updates in commit order, plus plain counters.
    logic [32:0]   ref_q [$];
    logic [CW-1:0] ref_br;
    logic [CW-1:0] ref_mp;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive, check at negedge, advance model, return just after posedge.
    task automatic cycle(input logic r, input logic v, input logic [31:0] pc,
                         input logic t, input logic m);
        logic ready_exp;
        rst = r; commit_valid = v; commit_pc = pc; commit_taken = t; commit_mispredict = m;
        @(negedge clk);
        ready_exp = (ref_q.size() < DEPTH);
        check_eq("commit_ready", commit_ready, ready_exp);
        check_eq("bp_update_en", bp_update_en, ref_q.size() != 0);
        if (ref_q.size() != 0) begin
            check_eq("bp_pc", bp_pc, ref_q[0][32:1]);
            check_eq("bp_taken", bp_branch_taken, ref_q[0][0]);
        end
        check_eq("branch_count", branch_count, ref_br);
        check_eq("mispredict_count", mispredict_count, ref_mp);
        if (r) begin
            ref_q.delete();
            ref_br = '0;
            ref_mp = '0;
        end else begin
            if (ref_q.size() != 0) void'(ref_q.pop_front());
            if (v && ready_exp) begin
                ref_q.push_back({pc, t});
                ref_br = ref_br + 1;
                if (m) ref_mp = ref_mp + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        ref_br = '0;
        ref_mp = '0;
        rst = 1'b1; commit_valid = 1'b0; commit_pc = '0; commit_taken = 1'b0; commit_mispredict = 1'b0;
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

        // Idle after reset, then single push.
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 32'h0000_1004, 1'b1, 1'b0);
        check_eq("single_en", bp_update_en, 1'b1);
        check_eq("single_pc", bp_pc, 32'h0000_1004);
        check_eq("single_taken", bp_branch_taken, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("single_drained", bp_update_en, 1'b0);
        check_eq("single_brcnt", branch_count, 1);

        // Ten back-to-back pushes, wrapping the pointers twice.
        for (int i = 0; i < 10; i++)
            cycle(1'b0, 1'b1, 32'h100 + 32'(4 * i), 1'(i % 2), 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        // Mispredict pattern after a fresh reset.
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        begin
            logic [4:0] pat;
            pat = 5'b01101;
            for (int i = 0; i < 5; i++)
                cycle(1'b0, 1'b1, 32'h2000 + 32'(4 * i), 1'b0, pat[i]);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("misp_br5", branch_count, 5);
        check_eq("misp_mp3", mispredict_count, 3);

        // Randomized traffic with occasional mid-stream resets.
        for (int i = 0; i < 400; i++) begin
            logic r;
            r = ($urandom_range(0, 49) == 0);
            cycle(r, ($urandom_range(0, 9) < 7), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                  1'($urandom), 1'($urandom));
        end

        // Reset with an entry pending: nothing issued afterwards, counters cleared.
        cycle(1'b0, 1'b1, 32'h0000_3000, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 32'h0000_3004, 1'b0, 1'b1);
        check_eq("rst_mid_en", bp_update_en, 1'b0);
        check_eq("rst_mid_ready", commit_ready, 1'b1);
        check_eq("rst_mid_br", branch_count, 0);
        check_eq("rst_mid_mp", mispredict_count, 0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
